// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 host transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_line_filter
// Description : Two-flop synchronizer, FILTER_LEN-sample level filter and
//               one-cycle falling-edge pulse for a single PS/2 line.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic                  sync1_q;
    logic                  sync2_q;
    logic [FILTER_LEN-1:0] hist_q;
    logic [FILTER_LEN-1:0] hist_d;
    logic                  level_q;
    logic                  level_d;
    logic                  fall_q;
    logic                  fall_d;

    // The level only moves once the whole sample window agrees.
    always_comb begin
        hist_d  = {hist_q[FILTER_LEN-2:0], sync2_q};
        level_d = level_q;
        if (&hist_d) begin
            level_d = 1'b1;
        end else if (~|hist_d) begin
            level_d = 1'b0;
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= '1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule : ps2_line_filter
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter with open-drain
//               line drive, ACK check and inter-edge watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA
);

    localparam int CNT_W = $clog2(max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] C_INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] C_WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic             clk_low_q, clk_low_d;
    logic             data_low_q, data_low_d;

    logic clk_level, clk_fall;
    logic data_level, data_fall_unused;
    logic accept;
    logic wd_expired;
    logic fail;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .line_in (PS2_CLK),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .rst     (rst),
        .line_in (PS2_DATA),
        .level   (data_level),
        .fall    (data_fall_unused)
    );

    assign tx_ready   = (state_q == IDLE);
    assign accept     = tx_valid && tx_ready;
    assign busy       = (state_q != IDLE) || accept;
    assign wd_expired = (cnt_q == C_WD_LIMIT);

    // Line drivers are flops so the pins never glitch; each *_d reflects the
    // level wanted in the coming cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;
        tx_done    = 1'b0;
        fail       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                bit_cnt_d  = 4'd0;
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                if (accept) begin
                    state_d    = INHIBIT;
                    shift_d    = {1'b1, odd_parity(tx_data), tx_data};
                    clk_low_d  = 1'b1;
                    data_low_d = (INHIBIT_CYCLES == 1);
                end
            end
            INHIBIT: begin
                clk_low_d = 1'b1;
                if (cnt_q == C_INH_PRE) begin
                    data_low_d = 1'b1;
                end
                if (cnt_q == C_INH_LAST) begin
                    state_d    = REQ;
                    cnt_d      = '0;
                    clk_low_d  = 1'b0;
                    data_low_d = 1'b1;
                end
            end
            REQ: begin
                if (clk_fall) begin
                    state_d    = SEND;
                    cnt_d      = '0;
                    data_low_d = ~shift_q[0];
                    shift_d    = {1'b1, shift_q[9:1]};
                    bit_cnt_d  = 4'd1;
                end else if (wd_expired) begin
                    fail = 1'b1;
                end
            end
            SEND: begin
                if (clk_fall) begin
                    cnt_d      = '0;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    data_low_d = ~shift_q[0];
                    shift_d    = {1'b1, shift_q[9:1]};
                    if (bit_cnt_q == 4'd9) begin
                        data_low_d = 1'b0;
                        state_d    = ACK;
                    end
                end else if (wd_expired) begin
                    fail = 1'b1;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    bit_cnt_d = 4'd11;
                    if (!data_level) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (wd_expired) begin
                    fail = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    tx_done = 1'b1;
                    state_d = IDLE;
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else if (wd_expired) begin
                    fail = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_error = fail;
        if (fail) begin
            state_d    = IDLE;
            cnt_d      = '0;
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '1;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
        end
    end

    assign PS2_CLK  = clk_low_q  ? 1'b0 : 1'bz;
    assign PS2_DATA = data_low_q ? 1'b0 : 1'bz;

endmodule : ps2_host_tx
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Scoreboard bench for ps2_host_tx with a PS/2 device model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 100;
    localparam int TMO  = 2000;
    localparam int FLT  = 4;
    localparam int HALF = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    wire        tx_ready, tx_done, tx_error, busy;
    wire        ps2_clk, ps2_data;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx_error (tx_error),
        .busy     (busy),
        .PS2_CLK  (ps2_clk),
        .PS2_DATA (ps2_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] rx_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int req_cyc  = 0;
    int err_cyc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a result.
    initial begin
        exp_t       e;
        logic [9:0] f;
        forever begin
            @(negedge clk);
            if (!rst && (tx_done === 1'b1 || tx_error === 1'b1)) begin
                if (tx_error === 1'b1) err_cyc = cyc;
                check("done_error_exclusive", {31'd0, tx_done & tx_error}, 0);
                check("busy_in_pulse", {31'd0, busy}, 1);
                check("ready_in_pulse", {31'd0, tx_ready}, 0);
                check("pulse_expected", {31'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("result_is_error", {31'd0, tx_error}, {31'd0, e.is_err});
                    if (!e.is_err) begin
                        check("rx_frame_present", {31'd0, rx_q.size() > 0}, 1);
                        if (rx_q.size() > 0) begin
                            f = rx_q.pop_front();
                            check("rx_data", {24'd0, f[7:0]}, {24'd0, e.data});
                            check("rx_parity", {31'd0, f[8]}, {31'd0, e.par});
                            check("rx_stop", {31'd0, f[9]}, 1);
                        end
                    end
                end
                @(negedge clk);
                check("busy_after_pulse", {31'd0, busy}, 0);
                check("ready_after_pulse", {31'd0, tx_ready}, 1);
                if (!dev_data_low) check("data_released", {31'd0, ps2_data}, 1);
                if (!dev_clk_low)  check("clk_released", {31'd0, ps2_clk}, 1);
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit push, input bit is_err, input bit par);
        int k = 0;
        while (tx_ready !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_send", {31'd0, tx_ready}, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        if (push) exp_q.push_back('{is_err, d, par});
        #1;
        check("busy_on_accept", {31'd0, busy}, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device model: checks inhibit and start bit, then clocks n_edges bits,
    // sampling host data just before each rising edge.
    task automatic device(input int n_edges, input bit ack, input bit glitch);
        logic [10:0] bits = '0;
        int k = 0;
        int low = 0;
        while (ps2_clk !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("inhibit_seen", {31'd0, ps2_clk}, 0);
        while (ps2_clk === 1'b0 && low < 1000) begin
            low++;
            @(negedge clk);
        end
        check("inhibit_len", low, INH);
        req_cyc = cyc;
        check("start_bit", {31'd0, ps2_data}, 0);
        repeat (50) @(negedge clk);
        for (int i = 1; i <= n_edges; i++) begin
            if (i == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (20) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            bits[i-1]   = ps2_data;
            dev_clk_low = 1'b0;
            if (i == 11) begin
                dev_data_low = 1'b0;
                if (ack) rx_q.push_back(bits[9:0]);
            end
            if (glitch && i >= 2 && i <= 9) begin
                repeat (HALF / 2) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (2) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF / 2 - 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic wait_resp(input int lim);
        int k = 0;
        while (exp_q.size() != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        check("response_seen", exp_q.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, tx_ready}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, tx_done}, 0);
        check("rst_error", {31'd0, tx_error}, 0);
        check("rst_clk_line", {31'd0, ps2_clk}, 1);
        check("rst_data_line", {31'd0, ps2_data}, 1);

        // 0xED: six ones -> odd parity bit 1
        send(CMD_SET_LED, 1'b1, 1'b0, 1'b1);
        device(11, 1'b1, 1'b0);
        wait_resp(2000);

        // 0x00: parity 1, data held low for every data bit
        send(8'h00, 1'b1, 1'b0, 1'b1);
        device(11, 1'b1, 1'b0);
        wait_resp(2000);

        // Missing ACK on the 11th clock
        send(CMD_ENABLE, 1'b1, 1'b1, 1'b0);
        device(11, 1'b0, 1'b0);
        wait_resp(2000);

        // Device never clocks: watchdog fires TMO cycles after REQ entry
        send(CMD_RESET, 1'b1, 1'b1, 1'b1);
        device(0, 1'b0, 1'b0);
        wait_resp(3000);
        check("timeout_latency", err_cyc - req_cyc, TMO);

        // Reset in the middle of SEND, then a normal 0xF4 (five ones -> parity 0)
        send(8'h00, 1'b0, 1'b0, 1'b1);
        device(5, 1'b0, 1'b0);
        check("mid_send_data_low", {31'd0, ps2_data}, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_data", {31'd0, ps2_data}, 1);
        check("async_rst_clk", {31'd0, ps2_clk}, 1);
        check("async_rst_ready", {31'd0, tx_ready}, 1);
        check("async_rst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(CMD_ENABLE, 1'b1, 1'b0, 1'b0);
        device(11, 1'b1, 1'b0);
        wait_resp(2000);

        // Short clock glitches during SEND must not shift extra bits
        send(CMD_RESET, 1'b1, 1'b0, 1'b1);
        device(11, 1'b1, 1'b1);
        wait_resp(2000);

        check("scoreboard_empty", exp_q.size(), 0);
        check("rx_queue_empty", rx_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule : tb_ps2_host_tx
`default_nettype wire
